// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: FSM states, command/reply bytes and the
// microsecond-to-clock-cycle conversion used by the transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        WAIT_CLK,
        SHIFT,
        ACK,
        DONE_WAIT,
        ERR
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned clk_hz);
        return (us * clk_hz) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       host_busy;

    modport master (
        output tx_valid, tx_byte,
        input  tx_ready, tx_done, tx_err, host_busy
    );

    modport slave (
        input  tx_valid, tx_byte,
        output tx_ready, tx_done, tx_err, host_busy
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pad: 2-FF synchronizer, FILT_CYC-sample debounce,
// and a one-cycle strobe when the debounced level falls.
module ps2_line_filter #(
    parameter int FILT_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Lines idle high (pulled up), so the filter starts from the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            fall  <= 1'b0;
            cnt   <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_CYC - 1)) begin
                level <= sync;
                fall  <= level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame
// with odd parity and stop bit, device ACK check, and start/transfer timeouts.
module ps2_host_tx #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int START_TO_US = 15000,
    parameter int XFER_TO_US  = 2000,
    parameter int FILT_CYC    = 8
) (
    input  logic               clk,
    input  logic               rst,
    ps2_host_tx_if.slave       bus,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    output logic               ps2_clk_oe,
    output logic               ps2_data_oe
);

    import ps2_pkg::*;

    localparam longint unsigned INH_CYC   = us_to_cycles(64'(INHIBIT_US), 64'(CLK_HZ));
    localparam longint unsigned START_CYC = us_to_cycles(64'(START_TO_US), 64'(CLK_HZ));
    localparam longint unsigned XFER_CYC  = us_to_cycles(64'(XFER_TO_US), 64'(CLK_HZ));
    localparam int TW = $clog2(64'(START_TO_US) * 64'(CLK_HZ / 1_000_000) + 64'd1);

    localparam logic [TW-1:0] INH_PRE   = TW'(INH_CYC - 64'd2);
    localparam logic [TW-1:0] INH_END   = TW'(INH_CYC - 64'd1);
    localparam logic [TW-1:0] START_END = TW'(START_CYC - 64'd1);
    localparam logic [TW-1:0] XFER_END  = TW'(XFER_CYC - 64'd1);

    state_t        state;
    logic [7:0]    shreg;
    logic          par;
    logic [3:0]    idx;
    logic [TW-1:0] timer;

    logic clk_lvl;
    logic clk_fall;
    logic data_lvl;
    logic data_fall_unused;

    ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_clk_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_data_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_data_in),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

    assign bus.tx_ready  = (state == IDLE);
    assign bus.host_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shreg       <= '0;
            par         <= 1'b0;
            idx         <= '0;
            timer       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            bus.tx_done <= 1'b0;
            bus.tx_err  <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            if (!(&timer)) timer <= timer + 1'b1;

            unique case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shreg      <= bus.tx_byte;
                        par        <= ~^bus.tx_byte;
                        timer      <= '0;
                        ps2_clk_oe <= 1'b1;
                        bus.tx_err <= 1'b0;
                        state      <= INHIBIT;
                    end
                end
                // Start bit is asserted one cycle before CLK is let go so DATA is
                // already low when the device sees the request-to-send.
                INHIBIT: begin
                    if (timer == INH_PRE) ps2_data_oe <= 1'b1;
                    if (timer == INH_END) begin
                        ps2_clk_oe <= 1'b0;
                        timer      <= '0;
                        state      <= WAIT_CLK;
                    end
                end
                WAIT_CLK: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        idx         <= 4'd1;
                        timer       <= '0;
                        state       <= SHIFT;
                    end else if (timer >= START_END) begin
                        state <= ERR;
                    end
                end
                // A fall is checked before the timeout so it wins a same-cycle tie.
                SHIFT: begin
                    if (clk_fall) begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else if (idx == 4'd8) begin
                            ps2_data_oe <= ~par;
                        end else begin
                            ps2_data_oe <= ~shreg[idx[2:0]];
                        end
                    end else if (timer >= XFER_END) begin
                        state <= ERR;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        state <= data_lvl ? ERR : DONE_WAIT;
                    end else if (timer >= XFER_END) begin
                        state <= ERR;
                    end
                end
                DONE_WAIT: begin
                    if (clk_lvl && data_lvl) begin
                        bus.tx_done <= 1'b1;
                        bus.tx_err  <= 1'b0;
                        state       <= IDLE;
                    end else if (timer >= XFER_END) begin
                        state <= ERR;
                    end
                end
                ERR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    bus.tx_done <= 1'b1;
                    bus.tx_err  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a PS/2 device model on pulled-up lines,
// run at a scaled 1 MHz clock so the 12.5 kHz device clock is 80 cycles.
module tb_ps2_host_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int INH    = 120;
    localparam int START  = 2500;
    localparam int XFER   = 2000;
    localparam int HALF   = 40;

    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_NOACK  = 2;
    localparam int M_ABORT  = 3;
    localparam int M_GLITCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic clk_line, data_line;

    assign clk_line  = !(ps2_clk_oe  || dev_clk_low);
    assign data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .CLK_HZ      (CLK_HZ),
        .INHIBIT_US  (INH),
        .START_TO_US (START),
        .XFER_TO_US  (XFER),
        .FILT_CYC    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;
    int rel_cyc = 0;
    int inh_run = 0, inh_ovl = 0, last_inh = 0, last_ovl = 0;
    int bfm_mode = M_NORMAL;
    bit bfm_active = 0, bfm_shifting = 0, bfm_aborted = 0;

    logic [9:0] frame_q[$];
    logic       done_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every tx_done pulse consumes one expected outcome.
    always @(negedge clk) begin
        if (bus.tx_done) begin
            done_cyc = cyc;
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("done_err", bus.tx_err, done_q.pop_front());
                chk("done_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                chk("done_ready", bus.tx_ready, 1'b1);
            end
        end
    end

    // Inhibit window length, start-bit overlap, and CLK release time.
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_run++;
            if (ps2_data_oe) inh_ovl++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            last_ovl = inh_ovl;
            rel_cyc  = cyc;
            inh_run  = 0;
            inh_ovl  = 0;
        end
    end

    // Device model: on request-to-send, clocks 10 bits, checks the frame, then ACKs.
    initial begin
        logic [9:0] got;
        bit p;
        bit stop;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (p && !ps2_clk_oe && ps2_data_oe && bfm_mode != M_SILENT) begin
                bfm_active = 1;
                stop = 0;
                got = '0;
                repeat (50) @(negedge clk);
                for (int k = 0; k < 10 && !stop; k++) begin
                    bfm_shifting = (k >= 1 && k <= 8);
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (bfm_mode == M_ABORT && k == 4) begin
                        repeat (10) @(negedge clk);
                        stop = 1;
                    end else begin
                        repeat (HALF / 2) @(negedge clk);
                        got[k] = data_line;
                        if (bfm_mode == M_GLITCH && k == 2) begin
                            repeat (3) @(negedge clk);
                            dev_clk_low = 1'b1;
                            repeat (5) @(negedge clk);
                            dev_clk_low = 1'b0;
                            repeat (HALF / 2 - 8) @(negedge clk);
                        end else begin
                            repeat (HALF / 2) @(negedge clk);
                        end
                    end
                end
                bfm_shifting = 0;
                if (stop) begin
                    bfm_aborted = 1;
                end else begin
                    if (frame_q.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
                    else chk("frame_bits", got, frame_q.pop_front());
                    if (bfm_mode != M_NOACK) dev_data_low = 1'b1;
                    repeat (20) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (HALF / 2) @(negedge clk);
                    dev_data_low = 1'b0;
                    repeat (HALF / 2) @(negedge clk);
                end
                bfm_active = 0;
            end
            p = ps2_clk_oe;
        end
    end

    task automatic issue(input logic [7:0] b);
        int n;
        for (n = 0; n < 100 && !bus.tx_ready; n++) @(negedge clk);
        if (!bus.tx_ready) chk("ready_timeout", 32'd0, 32'd1);
        bus.tx_byte  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input bit pulse_valid);
        bit seen;
        int busy_bad;
        seen = 0;
        busy_bad = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (bus.tx_done) begin
                seen = 1;
                break;
            end
            if (!bus.host_busy) busy_bad++;
            bus.tx_valid = pulse_valid && bfm_shifting && (n % 50 == 25);
            if (bus.tx_valid) bus.tx_byte = 8'h00;
        end
        bus.tx_valid = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        if (pulse_valid) chk("busy_whole_xfer", busy_bad, 0);
        for (int n = 0; n < 500 && bfm_active; n++) @(negedge clk);
        if (bfm_active) chk("bfm_idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic par, input int mode, input bit pulse_valid);
        bfm_mode = mode;
        if (mode != M_SILENT) frame_q.push_back({1'b1, par, b});
        done_q.push_back(mode == M_SILENT || mode == M_NOACK);
        issue(b);
        wait_done(pulse_valid);
    endtask

    logic [7:0] t2_byte [3] = '{8'h00, 8'hFF, 8'h01};
    logic       t2_par  [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_byte  = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        chk("rst_done", bus.tx_done, 1'b0);
        chk("rst_err", bus.tx_err, 1'b0);
        chk("rst_busy", bus.host_busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.tx_ready, 1'b1);

        // 1: set-LEDs command, frame 1,0,1,1,0,1,1,1 + parity 1 + stop 1
        send(8'hED, 1'b1, M_NORMAL, 1'b0);
        chk("inhibit_len", last_inh, INH);
        chk("start_bit_overlap", last_ovl, 1);

        // 2: parity corner bytes
        for (int i = 0; i < 3; i++) send(t2_byte[i], t2_par[i], M_NORMAL, 1'b0);

        // 3: device never clocks
        send(8'hEE, 1'b1, M_SILENT, 1'b0);
        if (done_cyc - rel_cyc < START - 5 || done_cyc - rel_cyc > START + 15)
            chk("start_timeout_delay", done_cyc - rel_cyc, START + 1);
        else
            chk("start_timeout_delay", 32'd1, 32'd1 & (done_cyc != 0));

        // 4: missing ACK; error flag stays up until the next accept
        send(8'hA5, 1'b1, M_NOACK, 1'b0);
        repeat (20) @(negedge clk);
        chk("err_held", bus.tx_err, 1'b1);
        chk("lines_idle_after_err", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // 5: asynchronous reset while data bit 4 (a zero) is driven
        bfm_mode = M_ABORT;
        issue(8'hED);
        for (int n = 0; n < 3000 && !bfm_aborted; n++) @(negedge clk);
        chk("abort_reached", bfm_aborted, 1'b1);
        chk("bit4_driven_low", ps2_data_oe, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("async_rst_data_oe", ps2_data_oe, 1'b0);
        chk("async_rst_busy", bus.host_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bfm_aborted = 0;
        repeat (200) @(negedge clk);
        send(8'hFF, 1'b1, M_NORMAL, 1'b0);

        // 6: tx_valid pulses mid-frame, CLK glitch, busy across the transfer
        send(8'h3C, 1'b1, M_GLITCH, 1'b1);

        chk("sb_done_drained", done_q.size(), 0);
        chk("sb_frame_drained", frame_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
